// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - host/datapath bundle for the AES round controller
//
// Purpose: groups the launch request and the round-sequencing outputs of
//          aes_round_ctrl so host, datapath and key schedule share one bundle.
// Parameters:
//   ROUND_W      width of the round index
// Signals:
//   start        host request, a rising edge launches an operation
//   mode         key size: 00=128, 01=192, 10=256, 11=reserved
//   enc_dec      1=encrypt, 0=decrypt
//   abort        cancel a running operation (only with AES_CTRL_ABORT_EN)
//   round        current round-key index
//   step         sub-cycle within the current round
//   first_round  initial AddRoundKey round is active
//   last_round   final round (no MixColumns) is active
//   mode_reg     key size latched at launch
//   enc_dec_reg  direction latched at launch
//   busy         operation in progress
//   done         one-cycle completion pulse
//   err          one-cycle pulse: launch rejected or operation aborted
// Modports: master = host side, slave = controller side.
// Optional feature macro: AES_CTRL_ABORT_EN adds the abort signal.

interface aes_round_ctrl_if #(
    parameter int ROUND_W = 4
) ();
    logic               start;
    logic [1:0]         mode;
    logic               enc_dec;
`ifdef AES_CTRL_ABORT_EN
    logic               abort;
`endif
    logic [ROUND_W-1:0] round;
    logic [2:0]         step;
    logic               first_round;
    logic               last_round;
    logic [1:0]         mode_reg;
    logic               enc_dec_reg;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
`ifdef AES_CTRL_ABORT_EN
        output abort,
`endif
        output start, mode, enc_dec,
        input  round, step, first_round, last_round, mode_reg, enc_dec_reg,
        input  busy, done, err
    );

    modport slave (
`ifdef AES_CTRL_ABORT_EN
        input  abort,
`endif
        input  start, mode, enc_dec,
        output round, step, first_round, last_round, mode_reg, enc_dec_reg,
        output busy, done, err
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - parametrised AES-128/192/256 round-sequencing controller
//
// Purpose: sequences the round index (up for encrypt, down for decrypt) and the
//          per-round sub-cycle step for an iterative AES datapath, with a
//          busy/done handshake to the host and an err pulse for rejected launches.
// Parameters:
//   CYC_PER_ROUND  cycles each round index is held (1..8)
//   ROUND_W        width of the round index (>=4)
// Ports:
//   i_clk          clock
//   i_reset        synchronous active-high reset
//   bus            aes_round_ctrl_if slave modport (start/mode/enc_dec in,
//                  round/step/first_round/last_round/mode_reg/enc_dec_reg/
//                  busy/done/err out)
// Optional feature macro: AES_CTRL_ABORT_EN adds bus.abort, which cancels a
//   running operation (back to IDLE, err pulse, no done).

module aes_round_ctrl #(
    parameter int CYC_PER_ROUND = 1,
    parameter int ROUND_W       = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    aes_round_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] STEP_LAST = 3'(CYC_PER_ROUND - 1);

    logic [1:0]         r_state;
    logic               r_start_prev;
    logic [ROUND_W-1:0] r_round;
    logic [2:0]         r_step;
    logic [1:0]         r_mode_reg;
    logic               r_enc_dec_reg;
    logic               r_err;

    logic               w_start_edge;
    logic               w_mode_ok;
    logic [ROUND_W-1:0] w_nr;
    logic               w_step_last;
    logic               w_at_first;
    logic               w_at_final;

    // Round count for a key size; the reserved code never reaches RUN.
    function automatic logic [ROUND_W-1:0] f_nr(input logic [1:0] m);
        case (m)
            2'b01:   f_nr = ROUND_W'(12);
            2'b10:   f_nr = ROUND_W'(14);
            default: f_nr = ROUND_W'(10);
        endcase
    endfunction

    assign w_start_edge = bus.start & ~r_start_prev;
    assign w_mode_ok    = (bus.mode != 2'b11);
    assign w_nr         = f_nr(r_mode_reg);
    assign w_step_last  = (r_step == STEP_LAST);
    // Decrypt walks the key schedule backwards, so first/final swap ends.
    assign w_at_first   = (r_round == (r_enc_dec_reg ? '0 : w_nr));
    assign w_at_final   = (r_round == (r_enc_dec_reg ? w_nr : '0));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_start_prev  <= 1'b0;
            r_round       <= '0;
            r_step        <= 3'd0;
            r_mode_reg    <= 2'b00;
            r_enc_dec_reg <= 1'b1;
            r_err         <= 1'b0;
        end else begin
            r_start_prev <= bus.start;
            r_err        <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE accepts a launch too, giving back-to-back operations.
                    if (w_start_edge && w_mode_ok) begin
                        r_state       <= S_RUN;
                        r_mode_reg    <= bus.mode;
                        r_enc_dec_reg <= bus.enc_dec;
                        r_step        <= 3'd0;
                        r_round       <= bus.enc_dec ? '0 : f_nr(bus.mode);
                    end else begin
                        r_state <= S_IDLE;
                        if (w_start_edge) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
`ifdef AES_CTRL_ABORT_EN
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_round <= '0;
                        r_step  <= 3'd0;
                        r_err   <= 1'b1;
                    end else
`endif
                    if (w_step_last) begin
                        r_step <= 3'd0;
                        // Final round holds its index so DONE still shows it.
                        if (w_at_final) begin
                            r_state <= S_DONE;
                        end else begin
                            r_round <= r_enc_dec_reg ? r_round + ROUND_W'(1)
                                                     : r_round - ROUND_W'(1);
                        end
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.round       = r_round;
    assign bus.step        = r_step;
    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.first_round = bus.busy & w_at_first;
    assign bus.last_round  = bus.busy & w_at_final;
    assign bus.mode_reg    = r_mode_reg;
    assign bus.enc_dec_reg = r_enc_dec_reg;
    assign bus.err         = r_err;

endmodule
